// File: rtl/memory_regfile.sv
// 32 x DATA_W register file: two combinational read ports and one synchronous write port.
// Register 0 is hardwired to zero. Optional same-cycle forwarding under `MEMORY_BYPASS_EN.
module memory_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic              we,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DATA_W-1:0] rs1_stored;
  logic [DATA_W-1:0] rs2_stored;

  // Entry 0 is a constant, so writes to it vanish and reads always see zero.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
    if (gi == 0) begin : g_zero
      assign regs[gi] = '0;
    end else begin : g_flop
      logic [DATA_W-1:0] q_reg;
      logic              wr_hit;

      assign wr_hit = we && (rd == ADDR_W'(gi));

      // Reset loads the entry's own index and wins over a coincident write.
      always_ff @(posedge clk) begin
        if (rst) begin
          q_reg <= DATA_W'(gi);
        end else if (wr_hit) begin
          q_reg <= rd_data;
        end
      end

      assign regs[gi] = q_reg;
    end
  end

  assign rs1_stored = regs[rs1];
  assign rs2_stored = regs[rs2];

`ifdef MEMORY_BYPASS_EN
  logic wr_live;

  // Forward the in-flight write so a reader sees it in the same cycle.
  assign wr_live  = we && !rst && (rd != '0);
  assign rs1_data = (wr_live && (rs1 == rd)) ? rd_data : rs1_stored;
  assign rs2_data = (wr_live && (rs2 == rd)) ? rd_data : rs2_stored;
`else
  assign rs1_data = rs1_stored;
  assign rs2_data = rs2_stored;
`endif

endmodule

// File: tb/tb_memory_regfile.sv
// Self-checking bench for memory_regfile: expected read values are queued as stimulus
// is driven and popped when the read ports are sampled.
module tb_memory_regfile;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        we;
  logic [4:0]  rd;
  logic [31:0] rd_data;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;

  int checks;
  int errors;
  logic [31:0] exp_q [$];
  logic [31:0] model [32];

  memory_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .rs1      (rs1),
    .rs2      (rs2),
    .we       (we),
    .rd       (rd),
    .rd_data  (rd_data),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Advance one rising edge; inputs change on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] e;
    rst = 1'b0; we = 1'b0; rd = '0; rd_data = '0; rs1 = '0; rs2 = '0;
    #1;
    exp_q.push_back(32'd0);
    e = exp_q.pop_front();
    checks++;
    if (rs1_data !== e) begin
      errors++;
      $display("FAIL pre_reset_x0 rs1_data got %h expected %h", rs1_data, e);
    end
    @(negedge clk);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rs1 = 5'(i); rs2 = 5'(i);
      exp_q.push_back(32'(i));
      exp_q.push_back(32'(i));
      #1;
      e = exp_q.pop_front();
      checks++;
      if (rs1_data !== e) begin
        errors++;
        $display("FAIL reset_sweep rs1=%0d rs1_data got %h expected %h", i, rs1_data, e);
      end
      e = exp_q.pop_front();
      checks++;
      if (rs2_data !== e) begin
        errors++;
        $display("FAIL reset_sweep rs2=%0d rs2_data got %h expected %h", i, rs2_data, e);
      end
      $display("txn reset_sweep idx=%0d rs1_data=%h rs2_data=%h", i, rs1_data, rs2_data);
      #9;
    end
    rs1 = 5'd31; rs2 = 5'd16;
    exp_q.push_back(32'd31);
    exp_q.push_back(32'd16);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (rs1_data !== e) begin
      errors++;
      $display("FAIL reset_top rs1_data got %h expected %h", rs1_data, e);
    end
    e = exp_q.pop_front();
    checks++;
    if (rs2_data !== e) begin
      errors++;
      $display("FAIL reset_mid rs2_data got %h expected %h", rs2_data, e);
    end
    @(negedge clk);
  endtask

  task automatic test_write_read();
    logic [31:0] e;
    we = 1'b1; rd = 5'd5; rd_data = 32'hDEADBEEF;
    $display("txn write rd=5 data=deadbeef");
    step();
    we = 1'b0; rs1 = 5'd5; rs2 = 5'd4;
    exp_q.push_back(32'hDEADBEEF);
    exp_q.push_back(32'd4);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (rs1_data !== e) begin
      errors++;
      $display("FAIL write_read rs1_data got %h expected %h", rs1_data, e);
    end
    e = exp_q.pop_front();
    checks++;
    if (rs2_data !== e) begin
      errors++;
      $display("FAIL write_read_neighbor rs2_data got %h expected %h", rs2_data, e);
    end
    @(negedge clk);
  endtask

  task automatic test_x0();
    logic [31:0] e;
    we = 1'b1; rd = 5'd0; rd_data = 32'hFFFFFFFF; rs1 = 5'd0; rs2 = 5'd0;
    exp_q.push_back(32'd0);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (rs1_data !== e) begin
      errors++;
      $display("FAIL x0_no_forward rs1_data got %h expected %h", rs1_data, e);
    end
    $display("txn write rd=0 data=ffffffff");
    @(negedge clk);
    step();
    we = 1'b0;
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (rs1_data !== e) begin
      errors++;
      $display("FAIL x0_protect rs1_data got %h expected %h", rs1_data, e);
    end
    e = exp_q.pop_front();
    checks++;
    if (rs2_data !== e) begin
      errors++;
      $display("FAIL x0_protect rs2_data got %h expected %h", rs2_data, e);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_priority();
    logic [31:0] e;
    rst = 1'b1; we = 1'b1; rd = 5'd3; rd_data = 32'h1234;
    $display("txn reset+write rd=3 data=1234");
    step();
    rst = 1'b0; we = 1'b0; rs2 = 5'd3; rs1 = 5'd5;
    exp_q.push_back(32'd3);
    exp_q.push_back(32'd5);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (rs2_data !== e) begin
      errors++;
      $display("FAIL reset_priority rs2_data got %h expected %h", rs2_data, e);
    end
    e = exp_q.pop_front();
    checks++;
    if (rs1_data !== e) begin
      errors++;
      $display("FAIL reset_clears_prior rs1_data got %h expected %h", rs1_data, e);
    end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    logic [31:0] e;
    we = 1'b1; rd = 5'd31; rd_data = 32'hAAAA5555;
    $display("txn write rd=31 data=aaaa5555");
    step();
    we = 1'b0; rs1 = 5'd31;
    exp_q.push_back(32'hAAAA5555);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (rs1_data !== e) begin
      errors++;
      $display("FAIL mid_reset_pre rs1_data got %h expected %h", rs1_data, e);
    end
    @(negedge clk);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.push_back(32'd31);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (rs1_data !== e) begin
      errors++;
      $display("FAIL mid_reset rs1_data got %h expected %h", rs1_data, e);
    end
    @(negedge clk);
  endtask

  task automatic test_collision();
    logic [31:0] e;
    we = 1'b1; rd = 5'd7; rd_data = 32'h55; rs1 = 5'd7; rs2 = 5'd6;
`ifdef MEMORY_BYPASS_EN
    exp_q.push_back(32'h55);
`else
    exp_q.push_back(32'd7);
`endif
    exp_q.push_back(32'd6);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (rs1_data !== e) begin
      errors++;
      $display("FAIL collision_before_edge rs1_data got %h expected %h", rs1_data, e);
    end
    e = exp_q.pop_front();
    checks++;
    if (rs2_data !== e) begin
      errors++;
      $display("FAIL collision_other_port rs2_data got %h expected %h", rs2_data, e);
    end
    $display("txn write rd=7 data=55 (collision)");
    @(negedge clk);
    step();
    we = 1'b0;
    exp_q.push_back(32'h55);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (rs1_data !== e) begin
      errors++;
      $display("FAIL collision_after_edge rs1_data got %h expected %h", rs1_data, e);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    logic [31:0] d;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'(i);
    // Consecutive writes; each cycle reads the previously written entry and the live target.
    for (int k = 1; k <= 12; k++) begin
      d = $urandom;
      we = 1'b1; rd = 5'(k); rd_data = d;
      rs1 = 5'(k - 1); rs2 = 5'(k);
      exp_q.push_back(model[k - 1]);
`ifdef MEMORY_BYPASS_EN
      exp_q.push_back(d);
`else
      exp_q.push_back(model[k]);
`endif
      #1;
      e = exp_q.pop_front();
      checks++;
      if (rs1_data !== e) begin
        errors++;
        $display("FAIL b2b_prev rs1=%0d rs1_data got %h expected %h", k - 1, rs1_data, e);
      end
      e = exp_q.pop_front();
      checks++;
      if (rs2_data !== e) begin
        errors++;
        $display("FAIL b2b_live rs2=%0d rs2_data got %h expected %h", k, rs2_data, e);
      end
      $display("txn write rd=%0d data=%h", k, d);
      @(negedge clk);
      step();
      model[k] = d;
    end
    we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(31 - i);
      exp_q.push_back(model[i]);
      exp_q.push_back(model[31 - i]);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (rs1_data !== e) begin
        errors++;
        $display("FAIL b2b_readback rs1=%0d rs1_data got %h expected %h", i, rs1_data, e);
      end
      e = exp_q.pop_front();
      checks++;
      if (rs2_data !== e) begin
        errors++;
        $display("FAIL b2b_readback rs2=%0d rs2_data got %h expected %h", 31 - i, rs2_data, e);
      end
      #9;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_write_read();
    test_x0();
    test_reset_priority();
    test_mid_reset();
    test_collision();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
